pipelined_rca_adder: RTL and testbench
======================================

// Module: pipelined_rca_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry adder for the DCT datapath: sums the partial
//   products of the approximate Vedic multiplier and accumulates DCT terms.
//   Splits a WIDTH-bit add into SEG-bit ripple segments, one segment per pipeline stage,
//   with the carry registered between stages. Valid/ready handshake on both sides, full
//   backpressure, one result per cycle at steady state.
// PARAMETERS
//   WIDTH        16  operand/sum width in bits; must be a multiple of SEG
//   SEG           4  bits resolved per pipeline stage; STAGES = WIDTH/SEG
//   APPROX_BITS   4  LSBs computed approximately when APPROX_LSB_EN is defined; 0..SEG
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      a/b/cin valid this cycle
//   in_ready   out  1      adder accepts a transfer this cycle
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      downstream accepts the result
//   sum        out  WIDTH  a+b+cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   - Reset: all stage valid bits 0, out_valid=0, sum=0, cout=0. in_ready is 1 once rst deasserts.
//   - Assert mid-operation: all in-flight operations are discarded with no partial output.
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - stall = out_valid & ~out_ready. in_ready = ~stall (combinational from out_ready).
//   - When stall=1, every stage register holds its value, including valid bits and carries.
//     When stall=0, all stages advance together, bubbles included.
//   - Stage k (0..STAGES-1):
//     - Adds bits [k*SEG +: SEG] with the registered carry from stage k-1.
//       Stage 0 uses cin instead.
//     - Resolved low bits of sum travel forward registered.
//     - Unresolved high operand bits travel forward registered.
//   - Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
//     Throughput is 1 op/cycle. Results leave in input order.
//   - Bubbles: in_valid=0 inserts an invalid slot. sum/cout hold their last valid value
//     while out_valid=0.
//   - Wrap: 0xFFFF+0x0001+0 -> sum=0x0000, cout=1. Same for the generic all-ones + 1 case.
//   - Stall boundary: in_valid=1 while stall=1 is not accepted. The source must hold a/b/cin.
//   - Stall release and new input in the same cycle: the pipeline advances and the new
//     input enters stage 0.
// CONFIGURATION
//   APPROX_LSB_EN defined:
//     - Bits [APPROX_BITS-1:0] use the approximate cell: sum_i = a_i | b_i.
//     - The carry out of that region is a[APPROX_BITS-1] & b[APPROX_BITS-1]. cin is ignored.
//     - Bits above the region are exact.
//     - With APPROX_BITS=0, behaviour is identical to the undefined case.
//   APPROX_LSB_EN undefined:
//     - All bits are exact. sum/cout equal a+b+cin. The APPROX_BITS parameter is unused.
//   Latency and handshake are identical in both builds.
// STRUCTURE
//   - Package adder_pkg:
//     - Function stages_f(WIDTH,SEG).
//     - typedef seg_t (logic [SEG-1:0]).
//     - Default constants WIDTH/SEG/APPROX_BITS.
//     - Function approx_fa for the approximate cell.
//   - Sub-module rca_segment:
//     - Combinational SEG-bit ripple of full adders: inputs a, b, cin; outputs s, co.
//     - Instantiated once per stage via generate.
//   - Top level holds only the stage registers, valid bits, stall logic and generate loop.
// TESTING
//   1. Reset/idle: assert rst for 3 cycles, then release -> out_valid=0, sum=0, cout=0,
//      in_ready=1.
//   2. Single op, exact build:
//      a=0x1234, b=0x4321, cin=0 -> after 4 cycles sum=0x5555, cout=0, out_valid for 1 cycle.
//   3. Carry through every stage boundary:
//      a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 at cycle 4.
//      a=0x8000, b=0x8000 -> sum=0x0000, cout=1.
//   4. Back-to-back with stall:
//      - Stream 8 random ops with out_ready=0 on cycles 6-8 -> in_ready=0 for those cycles.
//      - No result is lost or duplicated, and results stay in order against a golden model.
//   5. Reset mid-flight: 3 ops in flight, pulse rst -> out_valid=0 next edge, none emerges.
//   6. APPROX_LSB_EN, APPROX_BITS=4:
//      - a=0x000F, b=0x0001, cin=1 -> sum=0x000F, cout=0. Exact value would be 0x0011.
//      - a=0x0008, b=0x0008 -> sum=0x0018.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types, defaults and helpers for the pipelined ripple-carry adder.
package adder_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_SEG         = 4;
    localparam int DEF_APPROX_BITS = 4;

    typedef logic [DEF_SEG-1:0] seg_t;

    function automatic int stages_f(input int width, input int seg);
        return width / seg;
    endfunction

    // Approximate cell: {carry, sum} = {a & b, a | b}
    function automatic logic [1:0] approx_fa(input logic a, input logic b);
        return {a & b, a | b};
    endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple of full adders; the lowest APPROX bits use the approximate cell.
module rca_segment
    import adder_pkg::*;
#(
    parameter int SEG    = DEF_SEG,
    parameter int APPROX = 0
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic [SEG:0] w_c;
    logic         w_unused_cin;

    assign w_c[0]       = cin;
    // cin is dropped when the approximate region starts at bit 0
    assign w_unused_cin = w_c[0];

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        if (i < APPROX) begin : g_apx
            assign {w_c[i+1], s[i]} = approx_fa(a[i], b[i]);
        end else begin : g_fa
            assign s[i]     = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = w_c[SEG];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one SEG-bit segment per stage, carry registered between stages.
// Optional APPROX_LSB_EN macro makes the APPROX_BITS LSBs use the approximate OR cell.
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SEG         = DEF_SEG,
    parameter int APPROX_BITS = DEF_APPROX_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = stages_f(WIDTH, SEG);
`ifdef APPROX_LSB_EN
    localparam int APX = APPROX_BITS;
`else
    localparam int APX = 0;
`endif

    if ((WIDTH % SEG) != 0 || APPROX_BITS < 0 || APPROX_BITS > SEG) begin : g_bad_cfg
        $error("pipelined_rca_adder: bad WIDTH/SEG/APPROX_BITS");
    end

    logic [STAGES-1:0]            r_vld;
    logic [STAGES-1:0]            r_c;
    logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_s;

    logic [STAGES-1:0]            w_v_in, w_c_in, w_seg_co;
    logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_s_in;
    logic [STAGES-1:0][SEG-1:0]   w_seg_s;
    logic                         w_stall;
    logic                         w_unused;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_v_in[k] = in_valid;
            assign w_a_in[k] = a;
            assign w_b_in[k] = b;
            assign w_s_in[k] = '0;
            assign w_c_in[k] = cin;
        end else begin : g_next
            assign w_v_in[k] = r_vld[k-1];
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_s_in[k] = r_s[k-1];
            assign w_c_in[k] = r_c[k-1];
        end

        rca_segment #(
            .SEG   (SEG),
            .APPROX((k == 0) ? APX : 0)
        ) u_seg (
            .a  (w_a_in[k][k*SEG +: SEG]),
            .b  (w_b_in[k][k*SEG +: SEG]),
            .cin(w_c_in[k]),
            .s  (w_seg_s[k]),
            .co (w_seg_co[k])
        );
    end

    // Data only loads on a valid slot, so the last stage holds the last real result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_a[k]                <= w_a_in[k];
                    r_b[k]                <= w_b_in[k];
                    r_s[k]                <= w_s_in[k];
                    r_s[k][k*SEG +: SEG]  <= w_seg_s[k];
                    r_c[k]                <= w_seg_co[k];
                end
            end
        end
    end

    // Already-resolved operand bits and not-yet-resolved sum bits are dead in later stages
    assign w_unused = ^{r_a, r_b, r_s};

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed self-checking bench for pipelined_rca_adder (16-bit, 4 stages).
module tb_pipelined_rca_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(16), .SEG(4), .APPROX_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
`ifdef APPROX_LSB_EN
        logic [3:0]  lo;
        logic [12:0] hi;
        lo = x[3:0] | y[3:0];
        hi = {1'b0, x[15:4]} + {1'b0, y[15:4]} + {12'd0, x[3] & y[3]};
        return {hi, lo};
`else
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; op enters at the next edge, result must appear 4 edges later
    task automatic run_one(input vec_t v, input int id);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        for (int c = 1; c < 4; c++) begin
            chk($sformatf("v%0d early out_valid c%0d", id, c), 32'(out_valid), 32'd0);
            tick();
        end
        chk($sformatf("v%0d out_valid", id), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d sum", id), 32'(sum), 32'(v.s));
        chk($sformatf("v%0d cout", id), 32'(cout), 32'(v.co));
        tick();
        chk($sformatf("v%0d single-cycle valid", id), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d sum hold", id), 32'(sum), 32'(v.s));
    endtask

    initial begin
        logic [15:0] sa[8], sb[8];
        logic        sc[8];
        logic [16:0] exp_q[$];
        logic [16:0] e;
        int          idx, got, cyc;
        bit          seen;

`ifdef APPROX_LSB_EN
        tbl[0] = '{16'h000F, 16'h0001, 1'b1, 16'h000F, 1'b0};
        tbl[1] = '{16'h0008, 16'h0008, 1'b0, 16'h0018, 1'b0};
        tbl[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'hFFF8, 16'h0008, 1'b1, 16'h0008, 1'b1};
        tbl[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h0FFF, 1'b0};
        tbl[7] = '{16'h7FF0, 16'h0010, 1'b1, 16'h8000, 1'b0};
`else
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        tbl[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
`endif

        // Reset / idle
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_one(tbl[i], i);

        // Streaming with a 3-cycle downstream stall
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            sc[i] = 1'($urandom);
        end
        sa[0] = 16'hFFFF; sb[0] = 16'h0001; sc[0] = 1'b0;
        idx = 0; got = 0;
        for (cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = sa[idx]; b = sb[idx]; cin = sc[idx];
            end
            @(negedge clk);
            chk($sformatf("stream in_ready c%0d", cyc), 32'(in_ready), 32'(!(cyc >= 6 && cyc <= 8)));
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sa[idx], sb[idx], sc[idx]));
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream spurious result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream result %0d", got), 32'({cout, sum}), 32'(e));
                end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream results received", 32'(got), 32'd8);
        chk("stream queue drained", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        chk("stream no extra output", 32'(out_valid), 32'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst out_valid async", 32'(out_valid), 32'd0);
        tick();
        chk("midrst out_valid edge", 32'(out_valid), 32'd0);
        chk("midrst sum cleared", 32'(sum), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("midrst nothing emerges", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
